mem_req_queue: RTL and testbench

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

---
 rtl/mem_req_queue_pkg.sv | 22 ++
 rtl/mem_req_queue_if.sv | 41 ++++
 rtl/mem_req_queue_fifo.sv | 56 +++++
 rtl/mem_req_queue.sv | 140 ++++++++++++++
 tb/tb_mem_req_queue.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_queue_pkg.sv
// Shared types for the memory request queue:
// the queued request record and the issue FSM states.
package mem_req_pkg;

    localparam int ADDR_W = 32;
    // Widest data bus the request record can carry; narrower
    // instances leave the upper be/wdata bits at zero.
    localparam int MAX_W  = 128;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               we;
        logic [MAX_W/8-1:0] be;
        logic [MAX_W-1:0]   wdata;
    } mem_req_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_req_queue_if.sv
// Upstream request/response and downstream bus bundle.
// Signal suffixes are relative to the queue: slave is the queue's view,
// master is the view of whatever sits around it.
interface mem_req_queue_if #(
    parameter int MEM_W = 32
);

    logic               up_req_i;
    logic [31:0]        up_addr_i;
    logic               up_we_i;
    logic [MEM_W/8-1:0] up_be_i;
    logic [MEM_W-1:0]   up_wdata_i;
    logic               up_full_o;
    logic               up_rvalid_o;
    logic               up_err_o;
    logic [MEM_W-1:0]   up_rdata_o;

    logic               dn_req_o;
    logic [31:0]        dn_addr_o;
    logic               dn_we_o;
    logic [MEM_W/8-1:0] dn_be_o;
    logic [MEM_W-1:0]   dn_wdata_o;
    logic               dn_rvalid_i;
    logic               dn_err_i;
    logic [MEM_W-1:0]   dn_rdata_i;

    modport slave (
        input  up_req_i, up_addr_i, up_we_i, up_be_i, up_wdata_i,
        output up_full_o, up_rvalid_o, up_err_o, up_rdata_o,
        output dn_req_o, dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o,
        input  dn_rvalid_i, dn_err_i, dn_rdata_i
    );

    modport master (
        output up_req_i, up_addr_i, up_we_i, up_be_i, up_wdata_i,
        input  up_full_o, up_rvalid_o, up_err_o, up_rdata_o,
        input  dn_req_o, dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o,
        output dn_rvalid_i, dn_err_i, dn_rdata_i
    );

endinterface

// File: rtl/mem_req_queue_fifo.sv
// Request FIFO: DEPTH entries of WIDTH bits, head shown combinationally.
// Ports: clk/rst, push/wdata (tail), pop/rdata (head), count (occupancy).
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_queue.sv
// Queues upstream memory requests and issues them one at a time downstream,
// offsetting the address, with a response timeout.
// Ports: clk_i/rst_i, bus (mem_req_queue_if.slave), count_o, overflow_o,
// timeout_o (sticky).
module mem_req_queue
    import mem_req_pkg::*;
#(
    parameter int          MEM_W       = 32,
    parameter int          DEPTH       = 4,
    parameter logic [31:0] ADDR_OFFSET = 32'h0000_2000,
    parameter int          TIMEOUT     = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    mem_req_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   timeout_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int BE_W  = MEM_W / 8;
    localparam int WC_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The timeout fires at the edge where the wait counter would step
    // to TIMEOUT-1, i.e. while it still holds TIMEOUT-2.
    localparam logic [WC_W-1:0] WC_LAST =
        WC_W'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);

    mem_req_t         push_req;
    mem_req_t         head;
    state_t           state_q;
    state_t           state_d;
    logic [WC_W-1:0]  wc_q;
    logic [WC_W-1:0]  wc_d;
    logic             full;
    logic             push;
    logic             pop;
    logic             resp_ok;
    logic             resp_to;
    logic             to_hit;
    logic             unused_head;

    assign full          = (count_o == CNT_W'(DEPTH));
    assign push          = bus.up_req_i && !full;
    assign pop           = resp_ok || resp_to;
    assign bus.up_full_o = full;

    always_comb begin
        push_req                  = '0;
        push_req.addr             = bus.up_addr_i;
        push_req.we               = bus.up_we_i;
        push_req.be[BE_W-1:0]     = bus.up_be_i;
        push_req.wdata[MEM_W-1:0] = bus.up_wdata_i;
    end

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(mem_req_t))
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (push_req),
        .pop   (pop),
        .rdata (head),
        .count (count_o)
    );

    assign bus.dn_addr_o  = head.addr + ADDR_OFFSET;
    assign bus.dn_we_o    = head.we;
    assign bus.dn_be_o    = head.be[BE_W-1:0];
    assign bus.dn_wdata_o = head.wdata[MEM_W-1:0];
    assign unused_head    = ^{head.be, head.wdata};

    if (TIMEOUT > 0) begin : g_to
        assign to_hit = (wc_q == WC_LAST);
    end else begin : g_no_to
        assign to_hit = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        bus.dn_req_o = 1'b0;
        resp_ok      = 1'b0;
        resp_to      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Responses seen here are stale and dropped.
                if (count_o != '0) begin
                    bus.dn_req_o = 1'b1;
                    state_d      = S_WAIT;
                    wc_d         = '0;
                end
            end
            S_WAIT: begin
                if (bus.dn_rvalid_i) begin
                    resp_ok = 1'b1;
                    state_d = S_IDLE;
                end else if (to_hit) begin
                    resp_to = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wc_d = wc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            wc_q            <= '0;
            bus.up_rvalid_o <= 1'b0;
            bus.up_err_o    <= 1'b0;
            bus.up_rdata_o  <= '0;
            overflow_o      <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wc_q            <= wc_d;
            bus.up_rvalid_o <= pop;
            if (resp_ok) begin
                bus.up_rdata_o <= bus.dn_rdata_i;
                bus.up_err_o   <= bus.dn_err_i;
            end else if (resp_to) begin
                bus.up_rdata_o <= '0;
                bus.up_err_o   <= 1'b1;
            end
            if (bus.up_req_i && full) begin
                overflow_o <= 1'b1;
            end
            if (resp_to) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed cycle-by-cycle vectors for mem_req_queue (DEPTH 4, TIMEOUT 8),
// plus a hand-written write/error-response sequence.
module tb_mem_req_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    logic       ovf;
    logic       tmo;

    mem_req_queue_if #(.MEM_W(32)) bus ();

    mem_req_queue #(
        .MEM_W       (32),
        .DEPTH       (4),
        .ADDR_OFFSET (32'h0000_2000),
        .TIMEOUT     (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .count_o    (count),
        .overflow_o (ovf),
        .timeout_o  (tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic        rv;
        logic        er;
        logic [31:0] rd;
        logic        e_dreq;
        logic [31:0] e_daddr;
        logic [2:0]  e_cnt;
        logic        e_rv;
        logic        e_err;
        logic [31:0] e_rdata;
        logic        e_ovf;
        logic        e_to;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void v(
        input string n, input logic r, input logic q,
        input logic [31:0] a, input logic we, input logic [3:0] be,
        input logic rv, input logic er, input logic [31:0] rd,
        input logic dq, input logic [31:0] da, input logic [2:0] c,
        input logic erv, input logic eer, input logic [31:0] erd,
        input logic eo, input logic et);
        vec_t x;
        x.name = n;  x.rst = r;  x.req = q;  x.addr = a;
        x.we = we;  x.be = be;  x.rv = rv;  x.er = er;  x.rd = rd;
        x.e_dreq = dq;  x.e_daddr = da;  x.e_cnt = c;
        x.e_rv = erv;  x.e_err = eer;  x.e_rdata = erd;
        x.e_ovf = eo;  x.e_to = et;
        tbl.push_back(x);
    endfunction

    task automatic drive(input vec_t x);
        rst             = x.rst;
        bus.up_req_i    = x.req;
        bus.up_addr_i   = x.addr;
        bus.up_we_i     = x.we;
        bus.up_be_i     = x.be;
        bus.up_wdata_i  = ~x.addr;
        bus.dn_rvalid_i = x.rv;
        bus.dn_err_i    = x.er;
        bus.dn_rdata_i  = x.rd;
    endtask

    task automatic check_vec(input vec_t x);
        logic ok;
        ok = (bus.dn_req_o === x.e_dreq) && (count === x.e_cnt)
          && (bus.up_full_o === (x.e_cnt == 3'd4))
          && (bus.up_rvalid_o === x.e_rv) && (bus.up_err_o === x.e_err)
          && (bus.up_rdata_o === x.e_rdata)
          && (ovf === x.e_ovf) && (tmo === x.e_to);
        if (x.e_dreq) ok = ok && (bus.dn_addr_o === x.e_daddr);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h cnt=%0d full=%b rv=%b err=%b rdata=%h ovf=%b to=%b; want req=%b addr=%h cnt=%0d rv=%b err=%b rdata=%h ovf=%b to=%b",
                     x.name, bus.dn_req_o, bus.dn_addr_o, count,
                     bus.up_full_o, bus.up_rvalid_o, bus.up_err_o,
                     bus.up_rdata_o, ovf, tmo, x.e_dreq, x.e_daddr,
                     x.e_cnt, x.e_rv, x.e_err, x.e_rdata, x.e_ovf, x.e_to);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;

        // name rst req addr we be | rv er rd | dreq daddr cnt rv err rdata ovf to
        // Read, response 3 cycles after dn_req.
        v("A0",0,1,'h100,0,'hF, 0,0,0, 0,0,0, 0,0,0, 0,0);
        v("A1",0,0,0,0,0,       0,0,0, 1,'h2100,1, 0,0,0, 0,0);
        v("A2",0,0,0,0,0,       0,0,0, 0,0,1, 0,0,0, 0,0);
        v("A3",0,0,0,0,0,       0,0,0, 0,0,1, 0,0,0, 0,0);
        v("A4",0,0,0,0,0,       1,0,'hDEADBEEF, 0,0,1, 0,0,0, 0,0);
        v("A5",0,0,0,0,0,       0,0,0, 0,0,0, 1,0,'hDEADBEEF, 0,0);
        v("A6",0,0,0,0,0,       0,0,0, 0,0,0, 0,0,'hDEADBEEF, 0,0);
        // Address wrap, write with error response.
        v("B0",0,1,'hFFFF_F000,1,'h5, 0,0,0, 0,0,0, 0,0,'hDEADBEEF, 0,0);
        v("B1",0,0,0,0,0,       0,0,0, 1,'h1000,1, 0,0,'hDEADBEEF, 0,0);
        v("B2",0,0,0,0,0,       1,1,0, 0,0,1, 0,0,'hDEADBEEF, 0,0);
        v("B3",0,0,0,0,0,       0,0,0, 0,0,0, 1,1,0, 0,0);
        v("B4",0,0,0,0,0,       0,0,0, 0,0,0, 0,1,0, 0,0);
        // Back-to-back pushes, overflow, pop does not make room.
        v("C0",0,1,'h10,0,'hF,  0,0,0, 0,0,0, 0,1,0, 0,0);
        v("C1",0,1,'h20,0,'hF,  0,0,0, 1,'h2010,1, 0,1,0, 0,0);
        v("C2",0,1,'h30,0,'hF,  0,0,0, 0,0,2, 0,1,0, 0,0);
        v("C3",0,1,'h40,0,'hF,  0,0,0, 0,0,3, 0,1,0, 0,0);
        v("C4",0,1,'h50,0,'hF,  0,0,0, 0,0,4, 0,1,0, 0,0);
        v("C5",0,1,'h60,0,'hF,  1,0,'hA0, 0,0,4, 0,1,0, 1,0);
        v("C6",0,0,0,0,0,       0,0,0, 1,'h2020,3, 1,0,'hA0, 1,0);
        v("C7",0,0,0,0,0,       1,0,'hB0, 0,0,3, 0,0,'hA0, 1,0);
        v("C8",0,0,0,0,0,       0,0,0, 1,'h2030,2, 1,0,'hB0, 1,0);
        v("C9",0,0,0,0,0,       1,0,'hC0, 0,0,2, 0,0,'hB0, 1,0);
        v("C10",0,0,0,0,0,      0,0,0, 1,'h2040,1, 1,0,'hC0, 1,0);
        v("C11",0,0,0,0,0,      1,0,'hD0, 0,0,1, 0,0,'hC0, 1,0);
        v("C12",0,0,0,0,0,      0,0,0, 0,0,0, 1,0,'hD0, 1,0);
        v("C13",0,0,0,0,0,      0,0,0, 0,0,0, 0,0,'hD0, 1,0);
        // Timeout 8 cycles after dn_req, queued request issued next.
        v("D0",0,1,'h300,0,'hF, 0,0,0, 0,0,0, 0,0,'hD0, 1,0);
        v("D1",0,0,0,0,0,       0,0,0, 1,'h2300,1, 0,0,'hD0, 1,0);
        v("D2",0,1,'h400,0,'hF, 0,0,0, 0,0,1, 0,0,'hD0, 1,0);
        v("D3",0,0,0,0,0,       0,0,0, 0,0,2, 0,0,'hD0, 1,0);
        v("D4",0,0,0,0,0,       0,0,0, 0,0,2, 0,0,'hD0, 1,0);
        v("D5",0,0,0,0,0,       0,0,0, 0,0,2, 0,0,'hD0, 1,0);
        v("D6",0,0,0,0,0,       0,0,0, 0,0,2, 0,0,'hD0, 1,0);
        v("D7",0,0,0,0,0,       0,0,0, 0,0,2, 0,0,'hD0, 1,0);
        v("D8",0,0,0,0,0,       0,0,0, 0,0,2, 0,0,'hD0, 1,0);
        v("D9",0,0,0,0,0,       0,0,0, 1,'h2400,1, 1,1,0, 1,1);
        v("D10",0,0,0,0,0,      1,0,'h55, 0,0,1, 0,1,0, 1,1);
        v("D11",0,0,0,0,0,      0,0,0, 0,0,0, 1,0,'h55, 1,1);
        // Reset during WAIT, late response ignored.
        v("E0",0,1,'h500,0,'hF, 0,0,0, 0,0,0, 0,0,'h55, 1,1);
        v("E1",0,0,0,0,0,       0,0,0, 1,'h2500,1, 0,0,'h55, 1,1);
        v("E2",1,1,'h600,0,'hF, 0,0,0, 0,0,1, 0,0,'h55, 1,1);
        v("E3",0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);
        v("E4",0,0,0,0,0,       1,0,'h77, 0,0,0, 0,0,0, 0,0);
        v("E5",0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);

        rst             = 1'b1;
        bus.up_req_i    = 1'b0;
        bus.up_addr_i   = '0;
        bus.up_we_i     = 1'b0;
        bus.up_be_i     = '0;
        bus.up_wdata_i  = '0;
        bus.dn_rvalid_i = 1'b0;
        bus.dn_err_i    = 1'b0;
        bus.dn_rdata_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_cnt", 32'(count), 0);
        chk("reset_flags", {26'd0, bus.dn_req_o, bus.up_rvalid_o,
            bus.up_err_o, bus.up_full_o, ovf, tmo}, 0);
        chk("reset_rdata", bus.up_rdata_o, 0);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            check_vec(tbl[i]);
            @(negedge clk);
        end

        // Write field pass-through and error response.
        bus.up_req_i   = 1'b1;
        bus.up_addr_i  = 32'h40;
        bus.up_we_i    = 1'b1;
        bus.up_be_i    = 4'b0101;
        bus.up_wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        bus.up_req_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.dn_req_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wr_issue", 32'(seen), 1);
        chk("wr_addr", bus.dn_addr_o, 32'h2040);
        chk("wr_we", 32'(bus.dn_we_o), 1);
        chk("wr_be", 32'(bus.dn_be_o), 32'h5);
        chk("wr_wdata", bus.dn_wdata_o, 32'hCAFE_F00D);
        @(negedge clk);
        #1;
        chk("wr_one_pulse", 32'(bus.dn_req_o), 0);
        bus.dn_rvalid_i = 1'b1;
        bus.dn_err_i    = 1'b1;
        bus.dn_rdata_i  = 32'h1234;
        @(negedge clk);
        bus.dn_rvalid_i = 1'b0;
        bus.dn_err_i    = 1'b0;
        #1;
        chk("wr_rvalid", 32'(bus.up_rvalid_o), 1);
        chk("wr_err", 32'(bus.up_err_o), 1);
        chk("wr_rdata", bus.up_rdata_o, 32'h1234);
        @(negedge clk);
        #1;
        chk("hold_rvalid", 32'(bus.up_rvalid_o), 0);
        chk("hold_rdata", bus.up_rdata_o, 32'h1234);
        chk("hold_err", 32'(bus.up_err_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
